// File: rtl/sr_cmd_debouncer.sv
// -----------------------------------------------------------------------------
// sr_cmd_debouncer
//
// Converts two raw, bouncy push-buttons (set, reset) into clean, mutually
// exclusive one-cycle command pulses for a downstream SR flip-flop. Each
// button is synchronised, debounced and rising-edge detected. The two request
// streams are then arbitrated, and a hold-off window follows every command.
// The flip-flop therefore never sees s = r = 1.
//
// Parameters
//   DB_CYCLES      : cycles sync2 must differ from the stable value before the
//                    stable value flips (>= 2)
//   HOLDOFF_CYCLES : cycles after a command or conflict during which new
//                    requests are dropped (>= 1)
//
// Ports
//   clk        in  : single clock, rising edge
//   rst        in  : synchronous, active-high reset
//   set_btn    in  : raw asynchronous set button
//   reset_btn  in  : raw asynchronous reset button
//   s          out : registered one-cycle set pulse
//   r          out : registered one-cycle reset pulse
//   conflict   out : registered one-cycle pulse when both requests coincide
//   busy       out : high while the hold-off window is active
// -----------------------------------------------------------------------------
module sr_cmd_debouncer #(
  parameter int DB_CYCLES      = 16,
  parameter int HOLDOFF_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic set_btn,
  input  logic reset_btn,
  output logic s,
  output logic r,
  output logic conflict,
  output logic busy
);

  localparam int DB_W = $clog2(DB_CYCLES) + 1;
  localparam int HO_W = $clog2(HOLDOFF_CYCLES) + 1;

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HO_W-1:0] HOLD_LOAD = HO_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Channel 0 is set, channel 1 is reset.
  logic [1:0]      raw;
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      stable;
  logic [1:0]      stable_d;
  logic [DB_W-1:0] db_cnt [2];
  logic [1:0]      req;

  state_t          state_q,    state_d;
  logic [HO_W-1:0] hold_cnt_q, hold_cnt_d;
  logic            s_d, r_d, conflict_d;

  assign raw = {reset_btn, set_btn};

  // ---------------------------------------------------------------------------
  // Synchroniser, debounce and edge-detect state for both channels. This logic
  // runs continuously and does not depend on the FSM state.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples values from before the edge. This is what makes sync1 -> sync2 a
  // real two-stage chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      for (int ch = 0; ch < 2; ch++) begin
        db_cnt[ch] <= '0;
      end
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_d <= stable;
      for (int ch = 0; ch < 2; ch++) begin
        if (sync2[ch] != stable[ch]) begin
          // Flip only after DB_CYCLES consecutive differing samples. Any cycle
          // that agrees with the stable value restarts the count, which is
          // what rejects bounce.
          if (db_cnt[ch] == DB_LAST) begin
            stable[ch] <= sync2[ch];
            db_cnt[ch] <= '0;
          end else begin
            db_cnt[ch] <= db_cnt[ch] + 1'b1;
          end
        end else begin
          db_cnt[ch] <= '0;
        end
      end
    end
  end

  // Only a press (0 -> 1 of the debounced value) raises a request. A release
  // raises none.
  assign req = stable & ~stable_d;

  // ---------------------------------------------------------------------------
  // Arbitration / hold-off FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      s          <= 1'b0;
      r          <= 1'b0;
      conflict   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      s          <= s_d;
      r          <= r_d;
      conflict   <= conflict_d;
    end
  end

  // NOTE: every signal driven here gets a default before the case statement.
  // A path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    s_d        = 1'b0;
    r_d        = 1'b0;
    conflict_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          // Both requests at once are reported as a conflict instead of being
          // passed on. This keeps s = r = 1 away from the flip-flop.
          s_d        = (req == 2'b01);
          r_d        = (req == 2'b10);
          conflict_d = (req == 2'b11);
          state_d    = HOLD;
          hold_cnt_d = HOLD_LOAD;
        end
      end
      HOLD: begin
        // Requests are ignored here, including one that arrives in the exit
        // cycle. They are dropped, not queued.
        if (hold_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state_q is a flop, so busy rises on the same edge as the command pulse.
  // It stays high for exactly HOLDOFF_CYCLES cycles.
  assign busy = (state_q == HOLD);

endmodule

// File: tb/tb_sr_cmd_debouncer.sv
// -----------------------------------------------------------------------------
// tb_sr_cmd_debouncer
//
// Directed bench for sr_cmd_debouncer with DB_CYCLES = 4 and HOLDOFF_CYCLES = 3.
// Each scenario is a row of per-edge input patterns. Bit e of a pattern is the
// level that clock edge e samples. The rows also hold hand-computed edge
// numbers for the s, r and conflict pulses and the total count of busy cycles.
// With these parameters, a clean press first sampled at edge k pulses at
// edge k + 6.
// -----------------------------------------------------------------------------
module tb_sr_cmd_debouncer;

  localparam int DB      = 4;
  localparam int HO      = 3;
  localparam int SCN_LEN = 24;

  logic clk = 1'b0;
  logic rst;
  logic set_btn;
  logic reset_btn;
  logic s;
  logic r;
  logic conflict;
  logic busy;

  int tests_run    = 0;
  int tests_failed = 0;

  sr_cmd_debouncer #(
    .DB_CYCLES      (DB),
    .HOLDOFF_CYCLES (HO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .set_btn   (set_btn),
    .reset_btn (reset_btn),
    .s         (s),
    .r         (r),
    .conflict  (conflict),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, $signed(actual), $signed(expected));
    end
  endtask

  // Advances one clock edge and samples 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Releases both buttons and lets the release debounce settle. Falling edges
  // must not produce any command, and the FSM must end up idle.
  task automatic release_and_settle(input string tag);
    int pulses = 0;
    set_btn   = 1'b0;
    reset_btn = 1'b0;
    rst       = 1'b0;
    for (int e = 0; e < 16; e++) begin
      tick();
      if (s !== 1'b0 || r !== 1'b0 || conflict !== 1'b0) pulses++;
    end
    check({tag, "_release_pulses"}, pulses, 0);
    check({tag, "_release_busy"}, busy, 0);
  endtask

  task automatic run_scn(input string tag,
                         input logic [31:0] set_pat,
                         input logic [31:0] rb_pat,
                         input logic [31:0] rst_pat,
                         input int exp_s_edge,
                         input int exp_r_edge,
                         input int exp_c_edge,
                         input int exp_busy);
    int s_edge = -1, r_edge = -1, c_edge = -1;
    int s_cnt = 0, r_cnt = 0, c_cnt = 0, busy_cnt = 0, both = 0;
    for (int e = 0; e < SCN_LEN; e++) begin
      set_btn   = set_pat[e];
      reset_btn = rb_pat[e];
      rst       = rst_pat[e];
      tick();
      if (s === 1'b1) begin
        s_cnt++;
        if (s_edge < 0) s_edge = e;
      end
      if (r === 1'b1) begin
        r_cnt++;
        if (r_edge < 0) r_edge = e;
      end
      if (conflict === 1'b1) begin
        c_cnt++;
        if (c_edge < 0) c_edge = e;
      end
      if (busy === 1'b1) busy_cnt++;
      if (s !== 1'b0 && r !== 1'b0) both++;
    end
    check({tag, "_s_edge"}, s_edge, exp_s_edge);
    check({tag, "_s_count"}, s_cnt, (exp_s_edge < 0) ? 0 : 1);
    check({tag, "_r_edge"}, r_edge, exp_r_edge);
    check({tag, "_r_count"}, r_cnt, (exp_r_edge < 0) ? 0 : 1);
    check({tag, "_conflict_edge"}, c_edge, exp_c_edge);
    check({tag, "_conflict_count"}, c_cnt, (exp_c_edge < 0) ? 0 : 1);
    check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    check({tag, "_s_and_r"}, both, 0);
    release_and_settle(tag);
  endtask

  initial begin
    int nonzero = 0;
    rst       = 1'b1;
    set_btn   = 1'b0;
    reset_btn = 1'b0;

    // Reset values: checked during two reset cycles and for a while after.
    tick();
    check("reset_cycle1_outputs", {s, r, conflict, busy}, 4'b0000);
    tick();
    check("reset_cycle2_outputs", {s, r, conflict, busy}, 4'b0000);
    rst = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      if ({s, r, conflict, busy} !== 4'b0000) nonzero++;
    end
    check("post_reset_idle", nonzero, 0);

    // Each row: tag, set pattern, reset_btn pattern, rst pattern,
    // expected s edge, r edge, conflict edge (-1 = none), busy cycle count.

    // Clean set press from edge 0: s at edge 6, busy for 3 cycles.
    run_scn("clean", 32'hFFFF_FFFF, 32'h0000_0000, 32'h0, 6, -1, -1, 3);

    // reset_btn samples 1,0,1,0 then holds 1 from edge 4: r at edge 10.
    run_scn("bounce", 32'h0000_0000, 32'hFFFF_FFF5, 32'h0, -1, 10, -1, 3);

    // Both buttons rise together: conflict at edge 6, no s or r.
    run_scn("simul", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, -1, -1, 6, 3);

    // reset_btn one edge behind set_btn: its request lands inside HOLD.
    run_scn("holdoff", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0, 6, -1, -1, 3);

    // reset request in the cycle HOLD exits (counter = 0): dropped.
    run_scn("hold_exit", 32'hFFFF_FFFF, 32'hFFFF_FFF8, 32'h0, 6, -1, -1, 3);

    // reset request one cycle later, in IDLE: accepted at edge 6 + HO + 1.
    run_scn("earliest", 32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'h0, 6, 10, -1, 6);

    // set held; rst at edge 3 discards progress; restart at edge 4, s at 10.
    run_scn("rst_mid", 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0008, 10, -1, -1, 3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sr_cmd_debouncer.md
# sr_cmd_debouncer

Conditions two raw push-button inputs (set, reset) into clean, mutually exclusive single-cycle command pulses for the SR flip-flop stage. It sits directly upstream of that stage and drives its `s` and `r` inputs. It guarantees the flip-flop never sees the illegal `s=r=1` combination, so its output never goes to X. Each input is synchronised, debounced and rising-edge detected. The two request streams are then arbitrated, and a hold-off window is applied after every command.

## Interface
- `DB_CYCLES`, 16: consecutive cycles a synchronised input must differ from its stable value before the stable value flips; must be ≥ 2.
- `HOLDOFF_CYCLES`, 4: cycles after an emitted command (or conflict) during which new requests are dropped; must be ≥ 1.
- Counter widths are `$clog2` of the respective parameter, plus 1.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `set_btn` input 1: raw, asynchronous, bouncy set button.
- `reset_btn` input 1: raw, asynchronous, bouncy reset button.
- `s` output 1: registered one-cycle set pulse, connected to the flip-flop `s` input.
- `r` output 1: registered one-cycle reset pulse, connected to the flip-flop `r` input.
- `conflict` output 1: registered one-cycle pulse when both requests qualify in the same cycle.
- `busy` output 1: high while in HOLD.

## Operation
- **Reset.** `s`, `r`, `conflict` and `busy` are 0. Synchroniser flops, stable values, delayed stable values and all counters are 0. FSM is in IDLE.
- **Synchroniser.** Each channel has a 2-flop synchroniser (`sync1` → `sync2`).
- **Debounce, per channel.**
  - If `sync2` ≠ `stable`, the counter increments.
  - When the counter is at `DB_CYCLES-1` and `sync2` still differs, `stable` takes `sync2` and the counter clears.
  - Any cycle with `sync2` = `stable` clears the counter.
  - Debouncing runs continuously, regardless of FSM state.
- **Edge detect.** A channel raises a request in the cycle where `stable`=1 and `stable_d`=0. Falling edges (button release) raise no request.
- **FSM states.** IDLE and HOLD.
- **IDLE transitions.**
  - Set request only: `s`←1 next edge; go to HOLD.
  - Reset request only: `r`←1 next edge; go to HOLD.
  - Both requests in the same cycle: `conflict`←1; `s`, `r` stay 0; go to HOLD.
  - No request: stay in IDLE.
- **HOLD.**
  - The hold counter loads `HOLDOFF_CYCLES-1` on entry and decrements each cycle.
  - At 0, go to IDLE.
  - Requests arriving in HOLD are dropped, not queued.
- `s`, `r` and `conflict` are each high for exactly one cycle. `s` and `r` are never simultaneously 1.
- **Reset mid-operation.** `rst` asserted during debounce or HOLD returns everything to reset values on that edge. Any partially counted bounce is discarded.
- **Button held through reset release.** The stable value restarts at 0, so a held button produces one request after full debounce latency.

## Timing
- **Latency.**
  - Edge 0 is the first edge sampling raw=1, with raw held high thereafter.
  - `sync2`=1 after edge 1.
  - `stable`=1 after edge `DB_CYCLES+1`.
  - `s` (or `r`) is high in the cycle following edge `DB_CYCLES+2`.
- **Bounce filtering.** A raw glitch shorter than `DB_CYCLES` cycles (as seen at `sync2`) produces no pulse.
- **Hold-off.**
  - `busy` rises on the same edge as the emitted pulse and stays high for `HOLDOFF_CYCLES` cycles.
  - The earliest next pulse is on the edge `HOLDOFF_CYCLES+1` after the previous one.
- **Same-cycle request and HOLD exit.** A request in the same cycle that HOLD exits (counter=0) is dropped. A request must occur while in IDLE to be accepted.

## Test plan
All scenarios use `DB_CYCLES`=4 and `HOLDOFF_CYCLES`=3.

- **Reset values.** Drive `rst`=1 for 2 cycles with both buttons at 0 → `s`=`r`=`conflict`=`busy`=0 throughout and after release.
- **Clean press.** `set_btn` 0→1 and held → `s`=1 for exactly one cycle, at edge 6 after the first sampling edge; `r`=0; `busy`=1 for 3 cycles.
- **Bounce.** `reset_btn` toggles 1,0,1,0 on consecutive cycles, then holds 1 → exactly one `r` pulse, 4 debounce cycles after the last toggle settles; no extra pulses.
- **Simultaneous press.** Both buttons rise on the same edge → `conflict`=1 for one cycle; `s`=`r`=0; `busy`=1 for 3 cycles.
- **Hold-off drop.** Set pulse emitted; `reset_btn` stable rise lands 1 cycle later, inside HOLD → no `r` pulse, and no `r` pulse after HOLD ends either.
- **Reset mid-debounce.** `set_btn` high for 3 cycles, then `rst`=1 for 1 cycle while the button stays high → no `s` before reset; `s` pulses 6 edges after the post-reset sampling restart.
